serializador_piso: RTL and testbench
====================================

# serializador_piso

Parallel-in/serial-out transmitter for the team's 1-bit serial link. It accepts an NBITS_DATA-bit word through a valid/ready handshake and shifts it out LSB first, one bit per clk. The bit order matches the link's serial-in/parallel-out receiver: a receiver shifting in at its MSB and sampling on the same N edges holds the original word in its parallel output after the N-th edge. Back-to-back words stream with no idle gap.

## Interface

- NBITS_DATA, 4, word width in bits; legal range ≥ 2.
- clk  in  1  clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  sender offers load_data this cycle.
- load_data  in  NBITS_DATA  word to transmit; sampled only on handshake.
- load_ready  out  1  block can accept a word this cycle.
- serial_out  out  1  current serial bit; LSB of the word first.
- serial_valid  out  1  high while serial_out carries a word bit.
- word_done  out  1  high during the cycle the last bit (bit N-1) is on serial_out.

## Operation

- Internal state:
  - sh[NBITS_DATA-1:0], the shift register.
  - cnt, width $clog2(NBITS_DATA), the bit index.
  - FSM with states IDLE and SHIFT.
- Handshake: a word transfers on a posedge where load_valid && load_ready.
  - With load_ready low, load_valid and load_data are ignored. The sender holds them; nothing is lost or queued.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==NBITS_DATA-1). It is a combinational decode of registered state only and does not depend on load_valid.
- IDLE behaviour:
  - Outputs: serial_out=0, serial_valid=0, word_done=0.
  - On handshake: sh<=load_data, cnt<=0, state<=SHIFT.
- SHIFT behaviour:
  - Outputs: serial_out=sh[0], serial_valid=1, word_done=(cnt==NBITS_DATA-1).
  - If cnt<NBITS_DATA-1: sh<=sh>>1 (MSB filled with 0), cnt<=cnt+1.
  - If cnt==NBITS_DATA-1 and handshake: sh<=load_data, cnt<=0, stay in SHIFT (seamless back-to-back).
  - If cnt==NBITS_DATA-1 and no handshake: state<=IDLE, sh<=0, cnt<=0.
- Reset (asynchronous, may occur at any point):
  - Forces state=IDLE, sh=0, cnt=0.
  - serial_out, serial_valid and word_done go to 0 immediately, without waiting for clk.
  - After reset, load_ready=1; a handshake while reset is high is ignored.
  - A word in flight is discarded, never resumed; no partial word is completed.
- Counter never wraps past NBITS_DATA-1. An X or unreachable cnt value is not a legal state.

## Timing

- Handshake at edge k:
  - bit 0 on serial_out during the cycle after edge k;
  - bit i during the cycle after edge k+i;
  - bit N-1 (word_done=1) during the cycle after edge k+N-1.
- Latency: 1 cycle from handshake edge to first bit. A word occupies exactly NBITS_DATA cycles of serial_valid.
- Throughput: one word per NBITS_DATA cycles when load_valid is held. serial_valid never drops between back-to-back words.
- Receiver alignment: a receiver clocked on clk that shifts serial_out in on the edges ending each of the N bit cycles holds the word after edge k+N.
- Outputs are registered-state decodes only, with no combinational path from inputs to outputs. Exception: load_ready also depends only on state and cnt.

## Test plan

1. Reset, then handshake 4'b1011 → serial_out 1,1,0,1 on four consecutive cycles, serial_valid=1 for those 4 cycles, word_done only on the 4th; the attached receiver's data_out=4'b1011 after the 4th bit edge; block returns to IDLE with serial_out=0.
2. load_valid held high with 4'hA, then 4'h5 offered on the last-bit cycle → 8 contiguous valid cycles carrying 0,1,0,1,1,0,1,0; load_ready high only on cycles 0 (IDLE) and 4 and 8 (last bits); no gap.
3. During word 4'h0, load_valid=1 with 4'hF from bit cycle 1 → load_ready=0 on bit cycles 0–2, accepted on bit 3 cycle, next word shifts out 1,1,1,1.
4. Reset asserted mid-clock at bit 2 of 4'h6 → serial_valid/serial_out drop to 0 before the next edge; after release, 4'h9 shifts out cleanly as 1,0,0,1 with no residue of 4'h6.
5. NBITS_DATA=8, handshake 8'hC3 → 1,1,0,0,0,0,1,1, word_done on the 8th bit only, receiver (8-bit) shows 8'hC3.
6. load_valid=0 for 5 cycles after a word → stays IDLE, load_ready=1, serial_valid=0, serial_out=0 throughout.

Source files
------------

// File: rtl/serializador_piso.sv
// Parallel-in/serial-out transmitter: accepts a word over valid/ready and
// shifts it out LSB first, one bit per clock, streaming back-to-back words.
module serializador_piso #(
    parameter int NBITS_DATA = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [NBITS_DATA-1:0] load_data,
    output logic                  load_ready,
    output logic                  serial_out,
    output logic                  serial_valid,
    output logic                  word_done
);

    localparam int CW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS_DATA - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                r_state, w_state_next;
    logic [NBITS_DATA-1:0] r_sh, w_sh_next;
    logic [CW-1:0]         r_cnt, w_cnt_next;
    logic                  w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sh    <= w_sh_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

    always_comb begin
        w_state_next = r_state;
        w_sh_next    = r_sh;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_sh_next    = load_data;
                    w_cnt_next   = '0;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt != LAST) begin
                    w_sh_next  = r_sh >> 1;
                    w_cnt_next = r_cnt + 1'b1;
                end else if (load_valid) begin
                    // last bit cycle doubles as the load slot for seamless streaming
                    w_sh_next  = load_data;
                    w_cnt_next = '0;
                end else begin
                    w_state_next = IDLE;
                    w_sh_next    = '0;
                    w_cnt_next   = '0;
                end
            end
        endcase
    end

    assign load_ready   = (r_state == IDLE) || w_last;
    assign serial_out   = (r_state == SHIFT) && r_sh[0];
    assign serial_valid = (r_state == SHIFT);
    assign word_done    = w_last;

endmodule

// File: tb/tb_serializador_piso.sv
// Self-checking bench for serializador_piso: directed and random streams checked
// against a bit-queue model of the link, plus an 8-bit instance.
module tb_serializador_piso;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready, serial_out, serial_valid, word_done;

    logic       v8;
    logic [7:0] d8;
    logic       r8, so8, sv8, wd8;

    int n_cmp = 0;
    int n_err = 0;

    bit         q[$];   // bits still to appear on the line, front = current
    logic [3:0] wq[$];  // words in flight, oldest first
    logic [3:0] rx;     // attached receiver, shifts in at MSB

    serializador_piso #(.NBITS_DATA(4)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .serial_out(serial_out),
        .serial_valid(serial_valid), .word_done(word_done)
    );

    serializador_piso #(.NBITS_DATA(8)) dut8 (
        .clk(clk), .reset(reset), .load_valid(v8), .load_data(d8),
        .load_ready(r8), .serial_out(so8),
        .serial_valid(sv8), .word_done(wd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit busy;
        busy = (q.size() != 0);
        chk({tag, ".ready"}, 8'(load_ready), 8'(q.size() <= 1));
        chk({tag, ".valid"}, 8'(serial_valid), 8'(busy));
        chk({tag, ".out"}, 8'(serial_out), busy ? 8'(q[0]) : 8'd0);
        chk({tag, ".done"}, 8'(word_done), 8'(q.size() == 1));
    endtask

    // Advance one clock from a negedge; inputs must already be driven.
    task automatic tick(input string tag);
        bit         hs, sv_p, so_p, wd_p;
        logic [3:0] w, word;
        hs   = load_valid && (q.size() <= 1) && !reset;
        w    = load_data;
        sv_p = serial_valid;
        so_p = serial_out;
        wd_p = word_done;
        @(posedge clk);
        if (reset) begin
            q.delete();
            wq.delete();
        end else begin
            if (sv_p) rx = {so_p, rx[3:1]};
            if (wd_p && wq.size() != 0) begin
                word = wq.pop_front();
                chk({tag, ".rx"}, 8'(rx), 8'(word));
            end
            if (q.size() != 0) void'(q.pop_front());
            if (hs) begin
                for (int i = 0; i < 4; i++) q.push_back(w[i]);
                wq.push_back(w);
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drive(input bit v, input logic [3:0] d);
        load_valid = v;
        load_data  = d;
    endtask

    initial begin
        logic [7:0] c3;
        reset = 1'b1;
        drive(1'b0, 4'h0);
        v8 = 1'b0;
        d8 = 8'h00;
        rx = '0;
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        chk("reset.r8", 8'(r8), 8'd1);
        chk("reset.sv8", 8'(sv8), 8'd0);
        reset = 1'b0;
        @(negedge clk);
        check_outputs("idle0");

        // single word 1011
        drive(1'b1, 4'b1011);
        tick("t1.hs");
        drive(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) tick("t1");

        // held valid, back-to-back A then 5
        drive(1'b1, 4'hA);
        tick("t2.hs");
        drive(1'b1, 4'h5);
        for (int i = 0; i < 4; i++) tick("t2");
        drive(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) tick("t2.tail");

        // F offered early while 0 is shifting
        drive(1'b1, 4'h0);
        tick("t3.hs");
        drive(1'b1, 4'hF);
        for (int i = 0; i < 4; i++) tick("t3");
        drive(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) tick("t3.tail");

        // async reset mid-cycle at bit 2 of 6, then clean 9
        drive(1'b1, 4'h6);
        tick("t4.hs");
        drive(1'b0, 4'h0);
        tick("t4.b1");
        tick("t4.b2");
        #2 reset = 1'b1;
        #1;
        q.delete();
        wq.delete();
        check_outputs("t4.async");
        drive(1'b1, 4'h6);
        tick("t4.inrst");
        reset = 1'b0;
        drive(1'b1, 4'h9);
        tick("t4.hs9");
        drive(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) tick("t4.w9");

        // 8-bit instance, C3
        c3 = 8'hC3;
        v8 = 1'b1;
        d8 = c3;
        tick("t5.hs");
        v8 = 1'b0;
        d8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("t5.out", 8'(so8), 8'(c3[i]));
            chk("t5.valid", 8'(sv8), 8'd1);
            chk("t5.done", 8'(wd8), 8'(i == 7));
            chk("t5.ready", 8'(r8), 8'(i == 7));
            tick("t5.tick");
        end
        chk("t5.end_valid", 8'(sv8), 8'd0);
        chk("t5.end_out", 8'(so8), 8'd0);

        // idle for 5 cycles
        for (int i = 0; i < 5; i++) tick("t6.idle");

        // random streaming with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom));
            if ($urandom_range(0, 40) == 0) begin
                reset = 1'b1;
                #1;
                q.delete();
                wq.delete();
                check_outputs("rnd.async");
                tick("rnd.inrst");
                reset = 1'b0;
            end else begin
                tick("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
